tx8b10b_arbiter: RTL
====================

// Module: tx8b10b_arbiter
// PURPOSE
//  Round-robin packet arbiter sharing one Tx8b10b transmit FIFO among NUM_CH byte-stream
//  requesters. Grants one channel per packet and frames it as header, payload, checksum.
//  Writes into Tx8b10b dataIn/writeStrobe and honours its full flag. Sits between the
//  protocol sources and the serial 8b10b link.
// PARAMETERS
//  NUM_CH   4   number of requesters, 1..16
//  MAX_LEN  64  max payload bytes per packet, 1..255; longer packets are truncated
// PORTS
//  clk        in   1         system clock
//  rst        in   1         reset, synchronous, active-high
//  in_data    in   8*NUM_CH  channel c byte on [8c+7:8c]
//  in_valid   in   NUM_CH    channel c byte valid
//  in_last    in   NUM_CH    channel c byte is last of packet
//  in_ready   out  NUM_CH    channel c byte accepted when valid&ready
//  fifo_full  in   1         Tx8b10b full
//  fifo_data  out  8         to Tx8b10b dataIn
//  fifo_write out  1         to Tx8b10b writeStrobe
//  busy       out  1         packet in progress (state != IDLE)
//  grant_id   out  4         current/last granted channel
//  truncated  out  1         1-cycle pulse: packet cut at MAX_LEN
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0, fifo_write=0, fifo_data=0, busy=0, truncated=0,
//   grant_id=NUM_CH-1 (so ch0 wins first), checksum=0, count=0.
//  FSM IDLE->HDR->PAY->CHK->IDLE, one transition per clk max.
//  IDLE: if any in_valid, grant first valid channel scanning grant_id+1, +2, ... mod NUM_CH;
//   register grant_id, clear checksum/count, go HDR. No FIFO write in IDLE.
//  HDR: when !fifo_full: fifo_write=1, fifo_data={4'hA,grant_id}; go PAY. Else hold.
//  PAY: in_ready[grant_id]=!fifo_full, all other in_ready=0; in_ready never depends on
//   in_valid. On accept: fifo_write=1, fifo_data=in_data[grant] (same-cycle pass-through),
//   checksum^=byte, count++. If in_last: go CHK. Else if count==MAX_LEN-1 before the
//   increment: go CHK, truncated=1 next cycle; remaining bytes of that stream form a new
//   packet at a later grant.
//  CHK: when !fifo_full: fifo_write=1, fifo_data=checksum (XOR of payload bytes, header
//   excluded); go IDLE. grant_id holds, so next arbitration starts at grant_id+1.
//  fifo_write/fifo_data combinational from state, regs and granted input; fifo_data=0
//   when fifo_write=0. Never write while fifo_full=1.
//  Wire size per packet = payload+2 bytes. Minimum packet gap: 1 cycle (IDLE).
//  A requester dropping in_valid mid-packet stalls PAY; no timeout.
//  Header/checksum wait on fifo_full with no upper bound; grant is never revoked mid-packet.
//  NUM_CH=1: arbitration degenerates, grant_id always 0.
//  count width: clog2(MAX_LEN+1). checksum 8 bits, wraps naturally under XOR.
//  rst mid-packet: immediate return to reset values; a partial packet is not completed;
//   downstream framing recovers on the next 0xA_ header.
// TESTING
//  T1 ch1 sends 3 bytes 11,22,33 (last on 33), fifo_full=0 -> fifo writes A1,11,22,33,00,
//    busy 5 cycles.
//  T2 ch0 and ch2 valid after reset -> ch0 packet first, then ch2; repeat with all 4
//    valid -> grant order 0,1,2,3,0.
//  T3 fifo_full asserted during HDR, PAY and CHK for 3 cycles each -> no fifo_write,
//    in_ready=0, bytes resume unchanged, checksum correct.
//  T4 MAX_LEN=4, ch3 sends 6 bytes 01..06 -> A3,01,02,03,04,04 with truncated pulse;
//    next packet A3,05,06,03.
//  T5 rst asserted after 2 payload bytes -> next cycle all outputs at reset values;
//    next packet starts from ch0 with a fresh header.
//  T6 ch2 in_valid gaps mid-packet -> stalls without losing bytes; other channels stay
//    ungranted until CHK done.

Source files
------------

// File: rtl/tx8b10b_arbiter.sv
// Round-robin packet arbiter feeding one Tx8b10b transmit FIFO from NumCh byte streams.
// Each grant produces one frame: header {4'hA, channel}, payload bytes, XOR checksum.
module tx8b10b_arbiter #(
  parameter int unsigned NumCh  = 4,
  parameter int unsigned MaxLen = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*NumCh-1:0] in_data_i,
  input  logic [NumCh-1:0]   in_valid_i,
  input  logic [NumCh-1:0]   in_last_i,
  output logic [NumCh-1:0]   in_ready_o,
  input  logic               fifo_full_i,
  output logic [7:0]         fifo_data_o,
  output logic               fifo_write_o,
  output logic               busy_o,
  output logic [3:0]         grant_id_o,
  output logic               truncated_o
);

  localparam int unsigned     CntW       = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] LastCnt    = CntW'(MaxLen - 1);
  localparam logic [3:0]      ResetGrant = 4'(NumCh - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StChk} state_e;

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [7:0]      chk_q, chk_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            trunc_q, trunc_d;

  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;

  logic            arb_found;
  logic [3:0]      arb_pick;
  int unsigned     arb_idx;

  // Byte, valid and last of the currently granted channel.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (grant_q == 4'(c)) begin
        sel_data  = in_data_i[8*c +: 8];
        sel_valid = in_valid_i[c];
        sel_last  = in_last_i[c];
      end
    end
  end

  // Scan grant+1, grant+2, ... wrapping; the last granted channel is checked last.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = grant_q;
    arb_idx   = 0;
    for (int unsigned i = 1; i <= NumCh; i++) begin
      arb_idx = 32'(grant_q) + i;
      if (arb_idx >= NumCh) begin
        arb_idx = arb_idx - NumCh;
      end
      for (int unsigned c = 0; c < NumCh; c++) begin
        if (!arb_found && (c == arb_idx) && in_valid_i[c]) begin
          arb_found = 1'b1;
          arb_pick  = 4'(c);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    trunc_d      = 1'b0;
    fifo_write_o = 1'b0;
    fifo_data_o  = 8'h00;
    in_ready_o   = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d = arb_pick;
          chk_d   = 8'h00;
          cnt_d   = '0;
          state_d = StHdr;
        end
      end

      StHdr: begin
        if (!fifo_full_i) begin
          fifo_write_o = 1'b1;
          fifo_data_o  = {4'hA, grant_q};
          state_d      = StPay;
        end
      end

      StPay: begin
        // Ready follows only FIFO space so a source may rely on it before raising valid.
        for (int unsigned c = 0; c < NumCh; c++) begin
          in_ready_o[c] = (grant_q == 4'(c)) && !fifo_full_i;
        end
        if (sel_valid && !fifo_full_i) begin
          fifo_write_o = 1'b1;
          fifo_data_o  = sel_data;
          chk_d        = chk_q ^ sel_data;
          cnt_d        = cnt_q + CntW'(1);
          if (sel_last) begin
            state_d = StChk;
          end else if (cnt_q == LastCnt) begin
            state_d = StChk;
            trunc_d = 1'b1;
          end
        end
      end

      StChk: begin
        if (!fifo_full_i) begin
          fifo_write_o = 1'b1;
          fifo_data_o  = chk_q;
          state_d      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= ResetGrant;
      chk_q   <= 8'h00;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign grant_id_o  = grant_q;
  assign truncated_o = trunc_q;

endmodule
